// File: rtl/adder32_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder sequencer.
package adder32_seq_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_SLICE = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned calc_nslice(input int unsigned width, input int unsigned slice);
      return width / slice;
   endfunction

   // Index width never drops below one bit, even for a single-slice build.
   function automatic int unsigned calc_idx_w(input int unsigned nslice);
      return (nslice > 1) ? $clog2(nslice) : 1;
   endfunction

endpackage

// File: rtl/adder32_slice4_exact.sv
// Reference exact SLICE-bit adder slice; drop-in partner for the sequencer.
module adder32_slice4_exact
   import adder32_seq_pkg::*;
#(
   parameter int unsigned SLICE = DEF_SLICE
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] s,
   output logic             cout
);

   assign {cout, s} = (SLICE+1)'(a) + (SLICE+1)'(b) + (SLICE+1)'(cin);

endmodule

// File: rtl/adder32_slice_seq.sv
// Time-multiplexes an external SLICE-bit adder over WIDTH/SLICE cycles,
// chaining the carry and assembling the result behind valid/ready handshakes.
module adder32_slice_seq
   import adder32_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic [SLICE-1:0] slice_a,
   output logic [SLICE-1:0] slice_b,
   output logic             slice_cin,
   input  logic [SLICE-1:0] slice_s,
   input  logic             slice_cout
);

   localparam int unsigned NSLICE = calc_nslice(WIDTH, SLICE);
   localparam int unsigned IDX_W  = calc_idx_w(NSLICE);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, b_sh_q, sum_q;
   logic               carry_q;
   logic [IDX_W-1:0]   idx_q;
   logic               out_valid_q, busy_q;
   logic               accept, last;

   assign last = (idx_q == IDX_W'(NSLICE - 1));

   // Next-state, handshake and slice-drive decode.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      slice_a   = '0;
      slice_b   = '0;
      slice_cin = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            slice_a   = a_sh_q[SLICE-1:0];
            slice_b   = b_sh_q[SLICE-1:0];
            slice_cin = carry_q;
            if (last) state_d = DONE;
         end
         DONE: begin
            in_ready = out_ready;
            if (out_ready) state_d = in_valid ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
      accept = in_valid && in_ready;
   end

   // State register; status flags are registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= (state_d == DONE);
         busy_q      <= (state_d == RUN);
      end
   end

   // Operand shifting, carry chaining and result assembly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else if (accept) begin
         a_sh_q  <= a;
         b_sh_q  <= b;
         sum_q   <= '0;
         carry_q <= cin;
         idx_q   <= '0;
      end else if (state_q == RUN) begin
         sum_q[idx_q*SLICE +: SLICE] <= slice_s;
         carry_q <= slice_cout;
         a_sh_q  <= a_sh_q >> SLICE;
         b_sh_q  <= b_sh_q >> SLICE;
         if (!last) idx_q <= idx_q + IDX_W'(1);
      end
   end

   assign sum       = sum_q;
   assign cout      = carry_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

endmodule
